// File: rtl/memory_bus_arbiter.sv
// N-master to 1-slave packet memory bus arbiter with tagged response routing.
// Define MEMBUS_FIXED_PRIO_EN for fixed priority (lowest port wins); default is round-robin.
module memory_bus_arbiter #(
  parameter int unsigned NUM_MASTERS     = 4,
  parameter int unsigned MASTER_ID_WIDTH = 8,
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH      = 16,
  localparam int unsigned PORT_BITS      = $clog2(NUM_MASTERS),
  localparam int unsigned SID_WIDTH      = PORT_BITS + MASTER_ID_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_MASTERS*MASTER_ID_WIDTH-1:0] m_msID,
  input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0]   m_msAddress,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]      m_msData,
  input  logic [NUM_MASTERS-1:0]                 m_msWrite,
  input  logic [NUM_MASTERS-1:0]                 m_msValid,
  output logic [NUM_MASTERS-1:0]                 m_msReady,
  output logic [NUM_MASTERS*MASTER_ID_WIDTH-1:0] m_smID,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]      m_smData,
  output logic [NUM_MASTERS-1:0]                 m_smValid,
  input  logic [NUM_MASTERS-1:0]                 m_smReady,
  output logic [SID_WIDTH-1:0]                   s_msID,
  output logic [ADDRESS_WIDTH-1:0]               s_msAddress,
  output logic [DATA_WIDTH-1:0]                  s_msData,
  output logic                                   s_msWrite,
  output logic                                   s_msValid,
  input  logic                                   s_msReady,
  input  logic [SID_WIDTH-1:0]                   s_smID,
  input  logic [DATA_WIDTH-1:0]                  s_smData,
  input  logic                                   s_smValid,
  output logic                                   s_smReady
);

  logic                       req_vld_q, req_vld_d;
  logic [SID_WIDTH-1:0]       req_id_q, req_id_d;
  logic [ADDRESS_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0]      req_data_q, req_data_d;
  logic                       req_write_q, req_write_d;

  logic [NUM_MASTERS-1:0]     rsp_oh_q, rsp_oh_d;
  logic [MASTER_ID_WIDTH-1:0] rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0]      rsp_data_q, rsp_data_d;

  logic                       load_en_c;
  logic                       grant_vld_c;
  logic [PORT_BITS-1:0]       grant_c;
  logic [NUM_MASTERS-1:0]     pick_c;
  logic [MASTER_ID_WIDTH-1:0] sel_id_c;
  logic [ADDRESS_WIDTH-1:0]   sel_addr_c;
  logic [DATA_WIDTH-1:0]      sel_data_c;
  logic                       sel_write_c;
  logic [PORT_BITS-1:0]       rsp_tag_c;
  logic [NUM_MASTERS-1:0]     tag_oh_c;

`ifndef MEMBUS_FIXED_PRIO_EN
  logic [PORT_BITS-1:0]       rr_q, rr_d;
  logic [NUM_MASTERS-1:0]     hi_mask_c;
`endif

  assign load_en_c = !req_vld_q || s_msReady;

  // Grant: lowest requesting port, searched from the rr pointer upward then wrapping.
  always_comb begin
`ifdef MEMBUS_FIXED_PRIO_EN
    pick_c = m_msValid;
`else
    hi_mask_c = m_msValid & ~((NUM_MASTERS'(1) << rr_q) - NUM_MASTERS'(1));
    pick_c    = (|hi_mask_c) ? hi_mask_c : m_msValid;
`endif
    grant_vld_c = |m_msValid;
    grant_c     = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (pick_c[i]) grant_c = PORT_BITS'(i);
    end
  end

  always_comb begin
    sel_id_c    = '0;
    sel_addr_c  = '0;
    sel_data_c  = '0;
    sel_write_c = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_c == PORT_BITS'(i)) begin
        sel_id_c    = m_msID[i*MASTER_ID_WIDTH +: MASTER_ID_WIDTH];
        sel_addr_c  = m_msAddress[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_data_c  = m_msData[i*DATA_WIDTH +: DATA_WIDTH];
        sel_write_c = m_msWrite[i];
      end
    end
  end

  assign m_msReady = (grant_vld_c && load_en_c) ? (NUM_MASTERS'(1) << grant_c) : '0;

  // Request register holds its payload whenever nothing is accepted.
  always_comb begin
    req_vld_d   = req_vld_q;
    req_id_d    = req_id_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_write_d = req_write_q;
    if (load_en_c) begin
      req_vld_d = grant_vld_c;
      if (grant_vld_c) begin
        req_id_d    = {grant_c, sel_id_c};
        req_addr_d  = sel_addr_c;
        req_data_d  = sel_data_c;
        req_write_d = sel_write_c;
      end
    end
  end

`ifndef MEMBUS_FIXED_PRIO_EN
  always_comb begin
    rr_d = rr_q;
    if (grant_vld_c && load_en_c) begin
      rr_d = (grant_c == PORT_BITS'(NUM_MASTERS - 1)) ? '0 : grant_c + PORT_BITS'(1);
    end
  end
`endif

  // Out-of-range tags decode to zero, so such responses are accepted and dropped.
  assign rsp_tag_c = s_smID[SID_WIDTH-1 -: PORT_BITS];
  always_comb begin
    tag_oh_c = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (rsp_tag_c == PORT_BITS'(i)) tag_oh_c[i] = 1'b1;
    end
  end

  assign s_smReady = !(|rsp_oh_q) || |(rsp_oh_q & m_smReady);

  always_comb begin
    rsp_oh_d   = rsp_oh_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    if (s_smReady) begin
      rsp_oh_d = s_smValid ? tag_oh_c : '0;
      if (s_smValid) begin
        rsp_id_d   = s_smID[MASTER_ID_WIDTH-1:0];
        rsp_data_d = s_smData;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_vld_q   <= 1'b0;
      req_id_q    <= '0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_write_q <= 1'b0;
      rsp_oh_q    <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
`ifndef MEMBUS_FIXED_PRIO_EN
      rr_q        <= '0;
`endif
    end else begin
      req_vld_q   <= req_vld_d;
      req_id_q    <= req_id_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_write_q <= req_write_d;
      rsp_oh_q    <= rsp_oh_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
`ifndef MEMBUS_FIXED_PRIO_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign s_msValid   = req_vld_q;
  assign s_msID      = req_id_q;
  assign s_msAddress = req_addr_q;
  assign s_msData    = req_data_q;
  assign s_msWrite   = req_write_q;
  assign m_smValid   = rsp_oh_q;
  assign m_smID      = {NUM_MASTERS{rsp_id_q}};
  assign m_smData    = {NUM_MASTERS{rsp_data_q}};

endmodule
